// File: rtl/txfifo_rd_framer_pkg.sv
// Shared definitions for the TX FIFO read-side framer: default geometry,
// FSM state encoding and the end-of-packet empty-byte helper.
package txfifo_rd_framer_pkg;

    localparam int TXF_WIDTH   = 256;
    localparam int TXF_MAX_LEN = 9600;
    localparam int TXF_LEN_W   = 16;
    localparam int TXF_BYTES   = 32;
    localparam int TXF_MTY_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Empty byte lanes in the last word: (32 - len[4:0]) mod 32.
    function automatic logic [TXF_MTY_W-1:0] eop_mty(input logic [TXF_MTY_W-1:0] len_lo);
        return (~len_lo) + 1'b1;
    endfunction

endpackage

// File: rtl/txfifo_rd_framer_skid_buf2.sv
// Two-entry valid/ready buffer. Output is the oldest entry and stays
// stable until it is accepted. Occupancy is exported so the producer can
// budget its in-flight reads; the producer never pushes when it is full.
module tx_skid_buf2 #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] out_data,
    output logic [1:0]    occ
);

    logic [PW-1:0] mem0_q;
    logic [PW-1:0] mem1_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;
    logic          pop;

    assign out_valid = (occ_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = rd_ptr_q ? mem1_q : mem0_q;
    assign occ       = occ_q;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) mem1_q <= push_data;
                else          mem0_q <= push_data;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/txfifo_rd_framer.sv
// Read side of the TX data FIFO. Pops a header word carrying the frame byte
// length, then ceil(len/32) data words, and presents the frame as a
// valid/ready stream with sop/eop/mty. Illegal lengths raise err_len; an
// over-long frame is read out of the FIFO and discarded.
//
// Handshake: a word moves downstream in every cycle where tx_valid and
// tx_ready are both high. Once tx_valid is raised it stays high, with
// tx_data/sop/eop/mty/len unchanged, until that handshake happens.
//
// fifo_rdreq is built from registered state, the FIFO empty flag and the
// downstream pop only; fifo_q never feeds it. A data read is issued only
// if the skid buffer still has room for it after this cycle's pop and the
// word already returning, so the buffer never overflows and 1 word/clk is
// sustained with tx_ready held high.
module txfifo_rd_framer
    import txfifo_rd_framer_pkg::*;
#(
    parameter int WIDTH   = TXF_WIDTH,
    parameter int MAX_LEN = TXF_MAX_LEN,
    parameter int LEN_W   = TXF_LEN_W
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 fifo_rdempty,
    output logic                 fifo_rdreq,
    input  logic [WIDTH-1:0]     fifo_q,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic [TXF_MTY_W-1:0] tx_mty,
    output logic [LEN_W-1:0]     tx_len,
    output logic                 err_len,
    output logic [31:0]          frm_cnt,
    output state_t               dbg_state,
    output logic [1:0]           dbg_skid_occ
);

    localparam int CNT_W = LEN_W - 4;
    localparam int PW    = 2 + TXF_MTY_W + LEN_W + WIDTH;

    state_t                 state_q, state_d;
    logic                   en_q;
    logic                   q_vld_q;
    logic [CNT_W-1:0]       rem_issue_q;
    logic [CNT_W-1:0]       rem_ret_q;
    logic [CNT_W-1:0]       words_q;
    logic [LEN_W-1:0]       len_q;
    logic [TXF_MTY_W-1:0]   mty_q;
    logic                   err_q;
    logic                   err_d;
    logic [31:0]            frm_q;
    logic                   rdreq_c;

    logic [LEN_W-1:0]       hdr_len;
    logic [LEN_W:0]         hdr_sum;
    logic [CNT_W-1:0]       hdr_words;
    logic                   hdr_zero;
    logic                   hdr_long;

    logic                   fifo_avail;
    logic                   issue_left;
    logic                   last_ret;
    logic                   pop;
    logic [1:0]             occ;
    logic [2:0]             credit_sum;
    logic                   credit_ok;

    logic                   push;
    logic                   push_sop;
    logic                   push_eop;
    logic [PW-1:0]          push_data;
    logic                   sk_valid;
    logic [PW-1:0]          sk_data;
    logic                   sk_sop;
    logic                   sk_eop;
    logic [TXF_MTY_W-1:0]   sk_mty;

    // Header decode: length sits in the low LEN_W bits of the header word.
    assign hdr_len   = fifo_q[LEN_W-1:0];
    assign hdr_sum   = {1'b0, hdr_len} + (LEN_W+1)'(TXF_BYTES - 1);
    assign hdr_words = CNT_W'(hdr_sum >> 5);
    assign hdr_zero  = (hdr_len == '0);
    assign hdr_long  = (hdr_len > LEN_W'(MAX_LEN));

    // en_q keeps reads off for the first cycle after reset release.
    assign fifo_avail = !fifo_rdempty && en_q;
    assign issue_left = (rem_issue_q != '0);
    // With one-cycle read latency, the final outstanding word is on fifo_q now.
    assign last_ret   = q_vld_q && (rem_ret_q == CNT_W'(1));

    // Slots the buffer will hold after this cycle: occupancy, minus the
    // word leaving now, plus the word arriving on fifo_q now.
    assign pop        = sk_valid & tx_ready;
    assign credit_sum = {1'b0, occ} + {2'b00, q_vld_q} - {2'b00, pop};
    assign credit_ok  = (credit_sum < 3'd2);

    // Next-state and read-request decode.
    always_comb begin
        state_d = state_q;
        rdreq_c = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_avail) begin
                    rdreq_c = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (hdr_zero) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (hdr_long) begin
                    err_d   = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA, ST_DROP: begin
                if (last_ret) begin
                    // Fetch the next header while the buffer drains.
                    if (fifo_avail) begin
                        rdreq_c = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (fifo_avail && issue_left &&
                             ((state_q == ST_DROP) || credit_ok)) begin
                    rdreq_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, read tracking and per-frame header fields.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            q_vld_q     <= 1'b0;
            rem_issue_q <= '0;
            rem_ret_q   <= '0;
            words_q     <= '0;
            len_q       <= '0;
            mty_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= 1'b1;
            q_vld_q <= rdreq_c;
            err_q   <= err_d;
            if (state_q == ST_HDR) begin
                rem_issue_q <= hdr_words;
                rem_ret_q   <= hdr_words;
                words_q     <= hdr_words;
                len_q       <= hdr_len;
                mty_q       <= eop_mty(hdr_len[TXF_MTY_W-1:0]);
            end else if ((state_q == ST_DATA) || (state_q == ST_DROP)) begin
                if (rdreq_c && issue_left) rem_issue_q <= rem_issue_q - CNT_W'(1);
                if (q_vld_q)               rem_ret_q   <= rem_ret_q - CNT_W'(1);
            end
        end
    end

    // Completed-frame counter, stepped on each eop handshake.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            frm_q <= '0;
        end else if (tx_valid && tx_ready && tx_eop) begin
            frm_q <= frm_q + 32'd1;
        end
    end

    // Returned data words are tagged and pushed; dropped words are not.
    assign push      = (state_q == ST_DATA) && q_vld_q;
    assign push_sop  = (rem_ret_q == words_q);
    assign push_eop  = (rem_ret_q == CNT_W'(1));
    assign push_data = {push_sop, push_eop, (push_eop ? mty_q : '0), len_q, fifo_q};

    tx_skid_buf2 #(
        .PW (PW)
    ) u_skid (
        .clk       (clk),
        .reset_    (reset_),
        .push      (push),
        .push_data (push_data),
        .out_ready (tx_ready),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .occ       (occ)
    );

    assign sk_sop = sk_data[PW-1];
    assign sk_eop = sk_data[PW-2];
    assign sk_mty = sk_data[PW-3 -: TXF_MTY_W];

    assign fifo_rdreq   = rdreq_c;
    assign tx_valid     = sk_valid;
    assign tx_data      = sk_data[WIDTH-1:0];
    assign tx_len       = sk_data[WIDTH +: LEN_W];
    assign tx_sop       = sk_valid & sk_sop;
    assign tx_eop       = sk_valid & sk_eop;
    assign tx_mty       = tx_eop ? sk_mty : '0;
    assign err_len      = err_q;
    assign frm_cnt      = frm_q;
    assign dbg_state    = state_q;
    assign dbg_skid_occ = occ;

endmodule

// File: tb/tb_txfifo_rd_framer.sv
// Bench for txfifo_rd_framer: a queue-based FIFO model with one-cycle read
// latency feeds the block; each frame's expected beats are computed from its
// length when the frame is written and checked in order on the output.
module tb_txfifo_rd_framer;
  import txfifo_rd_framer_pkg::*;

  localparam int W       = 256;
  localparam int LW      = 16;
  localparam int MAX_LEN = 9600;
  localparam int PW_T    = 2 + 5 + LW + W;

  logic          clk = 1'b0;
  logic          reset_;
  logic          fifo_rdempty;
  logic          fifo_rdreq;
  logic [W-1:0]  fifo_q;
  logic          tx_valid;
  logic          tx_ready;
  logic [W-1:0]  tx_data;
  logic          tx_sop;
  logic          tx_eop;
  logic [4:0]    tx_mty;
  logic [LW-1:0] tx_len;
  logic          err_len;
  logic [31:0]   frm_cnt;
  state_t        dbg_state;
  logic [1:0]    dbg_skid_occ;

  txfifo_rd_framer dut (
    .clk          (clk),
    .reset_       (reset_),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq),
    .fifo_q       (fifo_q),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop),
    .tx_mty       (tx_mty),
    .tx_len       (tx_len),
    .err_len      (err_len),
    .frm_cnt      (frm_cnt),
    .dbg_state    (dbg_state),
    .dbg_skid_occ (dbg_skid_occ)
  );

  // clock
  always #5 clk = ~clk;

  // FIFO contents and scoreboard
  logic [W-1:0]    fifo_mem[$];
  logic [PW_T-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_frm = 0;
  int exp_err = 0;
  int err_seen = 0;
  int beats = 0;
  int first_req = -1;
  int first_val = -1;
  int first_hs = -1;
  int last_hs = -1;
  int ready_pct = 100;
  int empty_pct = 0;
  bit prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [PW_T-1:0] act, input logic [PW_T-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // driver: write header + data words into the FIFO model, predict beats
  task automatic send_frame(input int len);
    logic [W-1:0] w;
    int nw;
    bit legal;
    w = rand_word();
    w[15:0] = len[15:0];
    fifo_mem.push_back(w);
    nw = (len + 31) / 32;
    legal = (len > 0) && (len <= MAX_LEN);
    for (int i = 0; i < nw; i++) begin
      w = rand_word();
      fifo_mem.push_back(w);
      if (legal)
        exp_q.push_back({(i == 0), (i == nw - 1),
                         ((i == nw - 1) ? 5'(nw * 32 - len) : 5'd0),
                         len[15:0], w});
    end
    if (!legal) exp_err++;
    fifo_rdempty = 1'b0;
  endtask

  // one clock: check at negedge, then act as the FIFO and sink after posedge
  task automatic cycle();
    logic [PW_T-1:0] act;
    logic req;
    @(negedge clk);
    cyc++;
    chk("rdreq_when_empty", fifo_rdreq & fifo_rdempty, 0);
    chk("skid_occ_le2", dbg_skid_occ <= 2'd2, 1);
    chk("frm_cnt", frm_cnt, exp_frm);
    if (prev_stall) chk("valid_hold", tx_valid, 1);
    if (tx_valid) begin
      if (first_val < 0) first_val = cyc;
      act = {tx_sop, tx_eop, tx_mty, tx_len, tx_data};
      if (exp_q.size() == 0) begin
        chk("extra_beat", tx_valid, 0);
      end else begin
        chk("beat", act, exp_q[0]);
        if (tx_ready) begin
          if (tx_eop) exp_frm++;
          void'(exp_q.pop_front());
          beats++;
          last_hs = cyc;
          if (first_hs < 0) first_hs = cyc;
        end
      end
    end
    if (err_len) err_seen++;
    prev_stall = tx_valid & !tx_ready;
    req = fifo_rdreq;
    if (req && first_req < 0) first_req = cyc;
    @(posedge clk);
    #1;
    if (req && fifo_mem.size() != 0) fifo_q = fifo_mem.pop_front();
    fifo_rdempty = (fifo_mem.size() == 0) || ($urandom_range(99) < empty_pct);
    tx_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((fifo_mem.size() != 0 || exp_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (8) cycle();
  endtask

  task automatic clear_marks();
    first_req = -1;
    first_val = -1;
    first_hs = -1;
    last_hs = -1;
    beats = 0;
  endtask

  initial begin
    int n;
    reset_ = 1'b0;
    fifo_rdempty = 1'b0;
    fifo_q = '0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset state, with the FIFO claiming data to show reads stay off
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_rdreq", fifo_rdreq, 0);
    chk("rst_valid", tx_valid, 0);
    chk("rst_sop_eop", {tx_sop, tx_eop}, 0);
    chk("rst_mty", tx_mty, 0);
    chk("rst_len", tx_len, 0);
    chk("rst_err", err_len, 0);
    chk("rst_frm", frm_cnt, 0);
    chk("rst_occ", dbg_skid_occ, 0);
    @(posedge clk);
    #1;
    fifo_rdempty = 1'b1;
    reset_ = 1'b1;
    repeat (4) cycle();

    // 1: len=64, two full words; first-beat latency
    clear_marks();
    send_frame(64);
    run_drain(200);
    chk("t1_beats", beats, 2);
    chk("t1_latency", first_val - first_req, 4);

    // 2: partial last words
    send_frame(65);
    send_frame(1);
    run_drain(200);
    chk("t2_err_none", err_seen, 0);

    // 3: ten back-to-back len=96 frames at full rate
    clear_marks();
    for (int i = 0; i < 10; i++) send_frame(96);
    run_drain(500);
    chk("t3_beats", beats, 30);
    chk("t3_span", last_hs - first_hs, 47);

    // 4: random backpressure and FIFO underruns
    ready_pct = 50;
    empty_pct = 25;
    for (int i = 0; i < 4; i++) send_frame(300);
    for (int i = 0; i < 10; i++) send_frame($urandom_range(400, 1));
    run_drain(3000);
    ready_pct = 100;
    empty_pct = 0;

    // 5: zero length, over-long drop, then a good frame
    clear_marks();
    err_seen = 0;
    exp_err = 0;
    send_frame(0);
    send_frame(MAX_LEN + 1);
    send_frame(64);
    run_drain(1500);
    chk("t5_err_pulses", err_seen, exp_err);
    chk("t5_fifo_drained", fifo_mem.size(), 0);
    chk("t5_beats", beats, 2);

    // 6: asynchronous reset while beat 2 of a 5-word frame is presented
    clear_marks();
    send_frame(160);
    n = 0;
    while (beats < 2 && n < 100) begin
      cycle();
      n++;
    end
    chk("t6_reach_beat2", beats, 2);
    #2;
    reset_ = 1'b0;
    #1;
    chk("t6_rst_valid", tx_valid, 0);
    chk("t6_rst_rdreq", fifo_rdreq, 0);
    chk("t6_rst_sop_eop", {tx_sop, tx_eop}, 0);
    chk("t6_rst_frm", frm_cnt, 0);
    fifo_mem.delete();
    exp_q.delete();
    exp_frm = 0;
    prev_stall = 1'b0;
    fifo_rdempty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b1;
    repeat (2) cycle();
    send_frame(96);
    run_drain(200);
    chk("t6_frm_after", frm_cnt, 1);

    // random mix to finish
    ready_pct = 70;
    empty_pct = 10;
    for (int i = 0; i < 12; i++) send_frame($urandom_range(200, 1));
    run_drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
